regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port integer register file with an integrated busy-bit scoreboard, replacing the fixed 2-read/1-write, 32x32 register file in the RV32I core. It serves superscalar or multi-issue configurations: NRD combinational read ports, NWR synchronous write ports, and per-register pending-write tracking so the issue stage can detect RAW hazards. Register 0 reads as zero in all cases. Sits between decode/issue (reads, reservations) and writeback (writes, busy release).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, at least 2)
- NRD, 2, number of read ports (1..8)
- NWR, 1, number of write ports (1..4)
- AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- rd_addr_i  in  NRD x AW  read addresses
- rd_data_o  out  NRD x XLEN  read data, combinational
- rd_busy_o  out  NRD  busy bit of the addressed register, combinational
- wr_en_i  in  NWR  write enables
- wr_addr_i  in  NWR x AW  write addresses
- wr_data_i  in  NWR x XLEN  write data
- rsv_en_i  in  1  reserve destination (set busy)
- rsv_addr_i  in  AW  register to reserve
- flush_i  in  1  clear all busy bits (pipeline flush), data untouched
- rsv_conflict_o  out  1  rsv_en_i asserted while rsv_addr_i already busy (WAW indication), combinational

## Operation
- Reset: all registers 0, all busy bits 0. rd_data_o, rd_busy_o and rsv_conflict_o then evaluate combinationally and read 0 while reset_n is low.
- Read: rd_data_o[p] is the contents of reg[rd_addr_i[p]]. Address 0 always returns 0 and busy 0.
- Write: on each edge, every port w with wr_en_i[w]=1 and wr_addr_i[w]!=0 stores wr_data_i[w]. Writes to register 0 are discarded.
- Same-address multi-write in one cycle: the highest-indexed port wins. Writes to different addresses all commit.
- Scoreboard: busy[r] is set by rsv_en_i with rsv_addr_i=r (r!=0). It is cleared by any enabled write to r.
- Same-cycle reserve and write to the same r: the reservation wins, so busy stays 1. This is a newer producer.
- flush_i: clears every busy bit next edge and overrides a same-cycle reservation. Writes in the flush cycle still commit.
- Reserve of an already-busy register is permitted. rsv_conflict_o=1 that cycle. Busy stays 1.
- Reset asserted mid-operation: immediately clears all data and busy bits, regardless of clock.

## Timing
- Read latency 0 (combinational from rd_addr_i and stored state).
- Write-to-read latency 1 cycle without bypass: data written at edge N is visible on rd_data_o after edge N.
- Reserve-to-busy latency 1 cycle. A release by write is also visible after the edge.
- With bypass compiled in (see Configuration), write data and busy release are visible in the same cycle.
- No handshakes. Every input is sampled on every edge.

## Configuration
- REGFILE_BYPASS_EN defined: enables write-to-read bypass.
  - Each read port compares against all enabled wr_addr_i. On a nonzero address match it returns the wr_data_i of the highest-indexed matching port.
  - rd_busy_o reads 0 for a register being written that cycle, unless rsv_en_i targets the same register that cycle.
- REGFILE_BYPASS_EN undefined: reads return stored state only. rd_busy_o reflects stored busy bits only.

## Structure
- Shared package regfile_pkg holds:
  - default constants: XLEN_DEF, NREGS_DEF, NRD_DEF, NWR_DEF
  - the x0 address constant REG_ZERO
  - a typedef for a write-port bundle (en, addr, data), reused by writeback.
- One sub-module: regfile_scoreboard.
  - Owns the NREGS busy vector, reserve/release/flush priority and rsv_conflict_o.
  - Takes the write enable/address vectors as release inputs.
- The top module holds the data array, the write-port priority resolution and the optional bypass mux.

## Test plan
- Reset: load reg5=0xDEADBEEF, assert reset_n low asynchronously mid-cycle -> rd_data_o for reg5 = 0 immediately, all rd_busy_o = 0.
- x0: write 0x12345678 to reg0 -> read reg0 = 0. Reserve reg0 -> busy 0, rsv_conflict_o 0.
- Multi-write collision (NWR=2): port0 writes reg3=0x11, port1 writes reg3=0x22 in the same cycle -> next cycle reg3 = 0x22.
- Scoreboard: reserve reg7 -> busy=1 next cycle. Write reg7=0xA5 -> busy=0 next cycle.
  - Reserve and write reg7 in the same cycle -> busy stays 1.
  - Reserve reg7 again while busy -> rsv_conflict_o=1 that cycle.
- Flush: reserve reg2, reg9, reg31 -> flush_i for one cycle -> all busy 0, reg contents unchanged. Flush with a same-cycle reserve of reg4 -> reg4 not busy.
- Bypass: write reg10=0xCAFEF00D while reading reg10 on all read ports.
  - With REGFILE_BYPASS_EN: reads return 0xCAFEF00D in the same cycle.
  - Without it: reads return the old value, and the new value the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and the
// writeback stage that feeds it.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NRD_DEF   = 2;
  localparam int unsigned NWR_DEF   = 1;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);
  localparam int unsigned REG_ZERO  = 0;

  typedef struct packed {
    logic                en;
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and reservation bus between issue/writeback (master) and the
// register file (slave).
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = NRD_DEF,
  parameter int unsigned NWR   = NWR_DEF
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD-1:0][AW-1:0]   rd_addr_i;
  logic [NRD-1:0][XLEN-1:0] rd_data_o;
  logic [NRD-1:0]           rd_busy_o;
  logic [NWR-1:0]           wr_en_i;
  logic [NWR-1:0][AW-1:0]   wr_addr_i;
  logic [NWR-1:0][XLEN-1:0] wr_data_i;
  logic                     rsv_en_i;
  logic [AW-1:0]            rsv_addr_i;
  logic                     flush_i;
  logic                     rsv_conflict_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i, flush_i,
    input  rd_data_o, rd_busy_o, rsv_conflict_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i, flush_i,
    output rd_data_o, rd_busy_o, rsv_conflict_o
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservation sets, any enabled write releases,
// flush clears all; a same-cycle reservation beats a release.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NWR   = NWR_DEF,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NWR-1:0]         wr_en_i,
  input  logic [NWR-1:0][AW-1:0] wr_addr_i,
  input  logic                   rsv_en_i,
  input  logic [AW-1:0]          rsv_addr_i,
  input  logic                   flush_i,
  output logic [NREGS-1:0]       busy_o,
  output logic                   rsv_conflict_o
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;

  // Next busy vector: flush > reserve > release
  always_comb begin
    busy_nxt_s = busy_r;
    if (flush_i) begin
      busy_nxt_s = {NREGS{1'b0}};
    end else begin
      for (int w = 0; w < NWR; w++) begin
        busy_nxt_s[wr_addr_i[w]] = wr_en_i[w] ? 1'b0 : busy_nxt_s[wr_addr_i[w]];
      end
      busy_nxt_s[rsv_addr_i] = rsv_en_i ? 1'b1 : busy_nxt_s[rsv_addr_i];
    end
    busy_nxt_s[REG_ZERO] = 1'b0;
  end

  // Busy bit storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy_o         = busy_r;
  assign rsv_conflict_o = reset_n & rsv_en_i & busy_r[rsv_addr_i];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard. Optional same-cycle
// write-to-read bypass is compiled in with REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = NRD_DEF,
  parameter int unsigned NWR   = NWR_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_mp_if.slave  bus
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] regs_r;
  logic [NREGS-1:0][XLEN-1:0] regs_nxt_s;
  logic [NREGS-1:0]           busy_s;
  logic [NRD-1:0][XLEN-1:0]   rd_data_s;
  logic [NRD-1:0]             rd_busy_s;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_en_i        (bus.wr_en_i),
    .wr_addr_i      (bus.wr_addr_i),
    .rsv_en_i       (bus.rsv_en_i),
    .rsv_addr_i     (bus.rsv_addr_i),
    .flush_i        (bus.flush_i),
    .busy_o         (busy_s),
    .rsv_conflict_o (bus.rsv_conflict_o)
  );

  // Write merge: ascending port order lets the highest port win a collision
  always_comb begin
    regs_nxt_s = regs_r;
    for (int w = 0; w < NWR; w++) begin
      regs_nxt_s[bus.wr_addr_i[w]] = bus.wr_en_i[w] ? bus.wr_data_i[w]
                                                     : regs_nxt_s[bus.wr_addr_i[w]];
    end
    regs_nxt_s[REG_ZERO] = {XLEN{1'b0}};
  end

  // Data array storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_r <= {(NREGS*XLEN){1'b0}};
    end else begin
      regs_r <= regs_nxt_s;
    end
  end

  // Read ports; x0 never matches the bypass so it stays zero/not-busy
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_data_s[p] = regs_r[bus.rd_addr_i[p]];
      rd_busy_s[p] = busy_s[bus.rd_addr_i[p]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en_i[w] && (bus.wr_addr_i[w] == bus.rd_addr_i[p]) &&
            (bus.rd_addr_i[p] != AW'(REG_ZERO))) begin
          rd_data_s[p] = bus.wr_data_i[w];
          rd_busy_s[p] = (bus.rsv_en_i && (bus.rsv_addr_i == bus.rd_addr_i[p]))
                         ? rd_busy_s[p] : 1'b0;
        end else begin
          rd_data_s[p] = rd_data_s[p];
          rd_busy_s[p] = rd_busy_s[p];
        end
      end
`endif
      rd_data_s[p] = reset_n ? rd_data_s[p] : {XLEN{1'b0}};
      rd_busy_s[p] = reset_n & rd_busy_s[p];
    end
  end

  assign bus.rd_data_o = rd_data_s;
  assign bus.rd_busy_o = rd_busy_s;

endmodule
